// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V core: sequences fetch, decode,
// execute, memory and write-back for LW/SW/R-type/BEQ and counts retired instructions.
module multicycle_control #(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode,
   input  logic                 stall,
   output logic [1:0]           ALUop,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic                 MemtoReg,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 IorD,
   output logic                 RegWrite,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 PCWriteCond,
   output logic                 PCSource,
   output logic                 halted,
   output logic [3:0]           state,
   output logic [INSTRET_W-1:0] instret
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADDR  = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BRANCH   = 4'd8,
      S_HALT     = 4'd9
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [INSTRET_W-1:0]   r_instret;
   logic                   w_retire;

   logic [1:0] w_alu_op;
   logic       w_src_a;
   logic [1:0] w_src_b;
   logic       w_mem_to_reg;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_iord;
   logic       w_reg_write;
   logic       w_ir_write;
   logic       w_pc_write;
   logic       w_pc_write_cond;
   logic       w_pc_source;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else if (!stall) begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instret <= '0;
      end else if (!stall && w_retire) begin
         r_instret <= r_instret + 1'b1;
      end
   end

   // An instruction retires on the edge that leaves its final state.
   assign w_retire = (r_state == S_MEMWB)    || (r_state == S_MEMWRITE) ||
                     (r_state == S_RTYPE_WB) || (r_state == S_BRANCH);

   always_comb begin
      w_next = S_HALT;
      unique case (r_state)
         S_FETCH:    w_next = S_DECODE;
         S_DECODE: begin
            if (opcode == OP_LW || opcode == OP_SW) w_next = S_MEMADDR;
            else if (opcode == OP_R)                w_next = S_EXECUTE;
            else if (opcode == OP_BEQ)              w_next = S_BRANCH;
            else                                    w_next = S_HALT;
         end
         S_MEMADDR: begin
            if (opcode == OP_LW)      w_next = S_MEMREAD;
            else if (opcode == OP_SW) w_next = S_MEMWRITE;
            else                      w_next = S_HALT;
         end
         S_MEMREAD:  w_next = S_MEMWB;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: w_next = S_FETCH;
         S_EXECUTE:  w_next = S_RTYPE_WB;
         S_RTYPE_WB: w_next = S_FETCH;
         S_BRANCH:   w_next = S_FETCH;
         S_HALT:     w_next = S_HALT;
         default:    w_next = S_HALT;
      endcase
   end

   always_comb begin
      w_alu_op        = 2'b00;
      w_src_a         = 1'b0;
      w_src_b         = 2'b00;
      w_mem_to_reg    = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_iord          = 1'b0;
      w_reg_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_pc_source     = 1'b0;
      unique case (r_state)
         S_FETCH: begin
            w_mem_read = 1'b1;
            w_ir_write = 1'b1;
            w_pc_write = 1'b1;
            w_src_b    = 2'b01;
         end
         S_DECODE:   w_src_b = 2'b11;
         S_MEMADDR: begin
            w_src_a = 1'b1;
            w_src_b = 2'b10;
         end
         S_MEMREAD: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
         end
         S_MEMWB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
         end
         S_MEMWRITE: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
         end
         S_EXECUTE: begin
            w_src_a  = 1'b1;
            w_alu_op = 2'b10;
         end
         S_RTYPE_WB: w_reg_write = 1'b1;
         S_BRANCH: begin
            w_src_a         = 1'b1;
            w_alu_op        = 2'b01;
            w_pc_write_cond = 1'b1;
            w_pc_source     = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset blanks everything combinationally; stall only blocks state-changing writes.
   assign ALUop       = rst_n ? w_alu_op : 2'b00;
   assign ALUSrcA     = rst_n & w_src_a;
   assign ALUSrcB     = rst_n ? w_src_b : 2'b00;
   assign MemtoReg    = rst_n & w_mem_to_reg;
   assign MemRead     = rst_n & w_mem_read;
   assign IorD        = rst_n & w_iord;
   assign PCSource    = rst_n & w_pc_source;
   assign MemWrite    = rst_n & ~stall & w_mem_write;
   assign RegWrite    = rst_n & ~stall & w_reg_write;
   assign IRWrite     = rst_n & ~stall & w_ir_write;
   assign PCWrite     = rst_n & ~stall & w_pc_write;
   assign PCWriteCond = rst_n & ~stall & w_pc_write_cond;

   assign halted  = rst_n & (r_state == S_HALT);
   assign state   = r_state;
   assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (counter width 4 so wrap is reachable).
module tb_multicycle_control;

   localparam int IW = 4;

   logic          clk;
   logic          rst_n;
   logic [6:0]    opcode;
   logic          stall;
   logic [1:0]    ALUop;
   logic          ALUSrcA;
   logic [1:0]    ALUSrcB;
   logic          MemtoReg, MemRead, MemWrite, IorD, RegWrite;
   logic          IRWrite, PCWrite, PCWriteCond, PCSource, halted;
   logic [3:0]    state;
   logic [IW-1:0] instret;
   logic [13:0]   ctrl;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [IW-1:0] exp_ir   = '0;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   multicycle_control #(.INSTRET_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .stall(stall),
      .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg),
      .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .PCSource(PCSource), .halted(halted), .state(state), .instret(instret)
   );

   // {ALUop, ALUSrcA, ALUSrcB, MemtoReg, MemRead, MemWrite, IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, PCSource}
   assign ctrl = {ALUop, ALUSrcA, ALUSrcB, MemtoReg, MemRead, MemWrite, IorD,
                  RegWrite, IRWrite, PCWrite, PCWriteCond, PCSource};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [13:0] exp_ctrl(input int s);
      case (s)
         0: return 14'b00_0_01_0_1_0_0_0_1_1_0_0;
         1: return 14'b00_0_11_0_0_0_0_0_0_0_0_0;
         2: return 14'b00_1_10_0_0_0_0_0_0_0_0_0;
         3: return 14'b00_0_00_0_1_0_1_0_0_0_0_0;
         4: return 14'b00_0_00_1_0_0_0_1_0_0_0_0;
         5: return 14'b00_0_00_0_0_1_1_0_0_0_0_0;
         6: return 14'b10_1_00_0_0_0_0_0_0_0_0_0;
         7: return 14'b00_0_00_0_0_0_0_1_0_0_0_0;
         8: return 14'b01_1_00_0_0_0_0_0_0_0_1_1;
         default: return 14'b0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; opcode = OP_LW;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (ctrl !== 14'b0 || state !== 4'd0 || instret !== '0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: ctrl=%b state=%0d instret=%0d halted=%b required 0/0/0/0",
                     i, ctrl, state, instret, halted);
         end
         step();
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (PCWrite !== 1'b1 || IRWrite !== 1'b1 || MemRead !== 1'b1 || state !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_release: PCWrite=%b IRWrite=%b MemRead=%b state=%0d required 1/1/1/0",
                  PCWrite, IRWrite, MemRead, state);
      end
   endtask

   task automatic test_lw();
      int st[5] = '{0, 1, 2, 3, 4};
      opcode = OP_LW;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (state !== st[i][3:0] || ctrl !== exp_ctrl(st[i])) begin
            n_fail++;
            $display("FAIL lw_step%0d: state=%0d ctrl=%b required state=%0d ctrl=%b",
                     i, state, ctrl, st[i], exp_ctrl(st[i]));
         end
         n_checks++;
         if (MemWrite !== 1'b0 || (RegWrite & MemtoReg) !== (st[i] == 4)) begin
            n_fail++;
            $display("FAIL lw_strobes%0d: MemWrite=%b RegWrite&MemtoReg=%b", i, MemWrite, RegWrite & MemtoReg);
         end
         step();
      end
      exp_ir++;
      n_checks++;
      if (state !== 4'd0 || instret !== exp_ir) begin
         n_fail++;
         $display("FAIL lw_retire: state=%0d instret=%0d required 0/%0d", state, instret, exp_ir);
      end
   endtask

   task automatic test_sw_r_beq();
      int         st[11] = '{0, 1, 2, 5, 0, 1, 6, 7, 0, 1, 8};
      logic [6:0] op[11];
      for (int i = 0; i < 11; i++) op[i] = (i < 4) ? OP_SW : (i < 8) ? OP_R : OP_BEQ;
      for (int i = 0; i < 11; i++) begin
         opcode = op[i];
         #1;
         n_checks++;
         if (state !== st[i][3:0] || ctrl !== exp_ctrl(st[i])) begin
            n_fail++;
            $display("FAIL seq_step%0d: state=%0d ctrl=%b required state=%0d ctrl=%b",
                     i, state, ctrl, st[i], exp_ctrl(st[i]));
         end
         n_checks++;
         if ((ALUop == 2'b01) !== (st[i] == 8) || PCWriteCond !== (st[i] == 8)) begin
            n_fail++;
            $display("FAIL seq_branch%0d: ALUop=%b PCWriteCond=%b state=%0d", i, ALUop, PCWriteCond, state);
         end
         step();
         if (st[i] == 5 || st[i] == 7 || st[i] == 8) exp_ir++;
      end
      n_checks++;
      if (state !== 4'd0 || instret !== exp_ir) begin
         n_fail++;
         $display("FAIL seq_retire: state=%0d instret=%0d required 0/%0d", state, instret, exp_ir);
      end
   endtask

   task automatic test_halt();
      opcode = OP_BAD;
      step();
      n_checks++;
      if (state !== 4'd1 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_decode: state=%0d halted=%b required 1/0", state, halted);
      end
      step();
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if (state !== 4'd9 || halted !== 1'b1 || ctrl !== 14'b0 || instret !== exp_ir) begin
            n_fail++;
            $display("FAIL halt_hold%0d: state=%0d halted=%b ctrl=%b instret=%0d required 9/1/0/%0d",
                     i, state, halted, ctrl, instret, exp_ir);
         end
         step();
      end
      rst_n = 1'b0;
      #1;
      exp_ir = '0;
      n_checks++;
      if (state !== 4'd0 || halted !== 1'b0 || ctrl !== 14'b0 || instret !== exp_ir) begin
         n_fail++;
         $display("FAIL halt_reset: state=%0d halted=%b ctrl=%b instret=%0d required 0/0/0/0",
                  state, halted, ctrl, instret);
      end
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_stall_memwrite();
      opcode = OP_SW;
      step(); step(); step();
      stall = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (state !== 4'd5 || MemWrite !== 1'b0 || IorD !== 1'b1 || instret !== exp_ir) begin
            n_fail++;
            $display("FAIL stall_hold%0d: state=%0d MemWrite=%b IorD=%b instret=%0d required 5/0/1/%0d",
                     i, state, MemWrite, IorD, instret, exp_ir);
         end
         step();
      end
      stall = 1'b0;
      #1;
      n_checks++;
      if (state !== 4'd5 || MemWrite !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release: state=%0d MemWrite=%b required 5/1", state, MemWrite);
      end
      step();
      exp_ir++;
      n_checks++;
      if (state !== 4'd0 || MemWrite !== 1'b0 || instret !== exp_ir) begin
         n_fail++;
         $display("FAIL stall_retire: state=%0d MemWrite=%b instret=%0d required 0/0/%0d",
                  state, MemWrite, instret, exp_ir);
      end
   endtask

   task automatic test_stall_decode();
      opcode = OP_R;
      step();
      stall = 1'b1;
      opcode = OP_BAD;
      #1;
      step();
      n_checks++;
      if (state !== 4'd1 || ctrl !== exp_ctrl(1)) begin
         n_fail++;
         $display("FAIL stall_decode: state=%0d ctrl=%b required 1/%b", state, ctrl, exp_ctrl(1));
      end
      stall = 1'b0;
      opcode = OP_R;
      step();
      n_checks++;
      if (state !== 4'd6) begin
         n_fail++;
         $display("FAIL stall_decode_resume: state=%0d required 6", state);
      end
      step(); step();
      exp_ir++;
   endtask

   task automatic test_instret_wrap();
      opcode = OP_R;
      for (int k = 0; k < 16; k++) begin
         step(); step(); step(); step();
         exp_ir++;
         n_checks++;
         if (state !== 4'd0 || instret !== exp_ir) begin
            n_fail++;
            $display("FAIL wrap_instr%0d: state=%0d instret=%0d required 0/%0d", k, state, instret, exp_ir);
         end
      end
   endtask

   task automatic test_reset_midinstr();
      opcode = OP_LW;
      step(); step(); step();
      n_checks++;
      if (state !== 4'd3 || MemRead !== 1'b1 || IorD !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_memread: state=%0d MemRead=%b IorD=%b required 3/1/1", state, MemRead, IorD);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (state !== 4'd0 || ctrl !== 14'b0 || instret !== '0) begin
         n_fail++;
         $display("FAIL midrst_async: state=%0d ctrl=%b instret=%0d required 0/0/0", state, ctrl, instret);
      end
      step();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (state !== 4'd0 || ctrl !== exp_ctrl(0)) begin
         n_fail++;
         $display("FAIL midrst_release: state=%0d ctrl=%b required 0/%b", state, ctrl, exp_ctrl(0));
      end
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; opcode = 7'd0;
      test_reset();
      test_lw();
      test_sw_r_beq();
      test_halt();
      test_stall_memwrite();
      test_stall_decode();
      test_instret_wrap();
      test_reset_midinstr();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
